add_unit_scheduler: RTL and testbench

Controller that shares the single integer add/sub functional unit among the adder reservation stations and sequences each operation through its execute states. It round-robin arbitrates ready reservation-station entries, latches operands and tag, runs add in one execute cycle or subtract in two (invert, then add), and drives the common data bus (CDB) request/acknowledge handshake. It sits between the add reservation stations and the CDB arbiter.

---
 rtl/add_unit_scheduler_pkg.sv | 15 +
 rtl/add_unit_scheduler_rr_arbiter.sv | 41 ++++
 rtl/add_unit_scheduler.sv | 94 +++++++++
 tb/tb_add_unit_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add_unit_scheduler_pkg.sv
// add_unit_scheduler_pkg: shared op and state encodings for the add unit scheduler.
package add_unit_scheduler_pkg;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;

   typedef enum logic [2:0] {
      sIdle    = 3'd0,
      sAdd     = 3'd1,
      sInverse = 3'd2,
      sMAdd    = 3'd3,
      sWaitCdb = 3'd4
   } state_t;

endpackage

// File: rtl/add_unit_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; pointer holds the index after the last grant.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;

   always_comb begin
      int idx;
      logic found;
      gnt = '0;
      ptr_nxt = ptr;
      found = 1'b0;
      idx = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         idx = (idx >= N) ? idx - N : idx;
         if (en && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            ptr_nxt = PW'((idx + 1) % N);
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk)
      if (rst)
         ptr <= '0;
      else if (en && |req)
         ptr <= ptr_nxt;

endmodule

// File: rtl/add_unit_scheduler.sv
// add_unit_scheduler: shares one add/sub unit among reservation stations and drives the CDB handshake.
module add_unit_scheduler
   import add_unit_scheduler_pkg::*;
#(
   parameter int N_RS   = 4,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4
) (
   input  logic                clk,
   input  logic                RST,
   input  logic [N_RS-1:0]     rs_valid,
   input  logic [2*N_RS-1:0]   rs_op,
   input  logic [DATA_W*N_RS-1:0] rs_a,
   input  logic [DATA_W*N_RS-1:0] rs_b,
   input  logic [TAG_W*N_RS-1:0]  rs_tag,
   output logic [N_RS-1:0]     rs_grant,
   output logic                cdb_req,
   input  logic                cdb_ack,
   output logic [TAG_W-1:0]    cdb_tag,
   output logic [DATA_W-1:0]   cdb_data,
   output logic                busy
);

   state_t state, state_nxt;
   logic [DATA_W-1:0] a_q, b_q, sel_a, sel_b;
   logic [TAG_W-1:0]  tag_q, sel_tag;
   logic [1:0]        sel_op;
   logic              window, accept, sel_sub;

   assign window  = (state == sIdle) || (state == sWaitCdb && cdb_ack);
   assign accept  = |rs_grant;
   assign sel_sub = sel_op == ALU_SUB;
   assign cdb_req = state == sWaitCdb;
   assign busy    = state != sIdle;

   rr_arbiter #(.N(N_RS)) u_arb (
      .clk(clk),
      .rst(RST),
      .req(rs_valid),
      .en (window && !RST),
      .gnt(rs_grant)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      sel_tag = '0;
      sel_op = ALU_ADD;
      for (int i = 0; i < N_RS; i++)
         if (rs_grant[i]) begin
            sel_a = rs_a[i*DATA_W +: DATA_W];
            sel_b = rs_b[i*DATA_W +: DATA_W];
            sel_tag = rs_tag[i*TAG_W +: TAG_W];
            sel_op = rs_op[2*i +: 2];
         end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         sIdle:    state_nxt = accept ? (sel_sub ? sInverse : sAdd) : sIdle;
         sAdd:     state_nxt = sWaitCdb;
         sInverse: state_nxt = sMAdd;
         sMAdd:    state_nxt = sWaitCdb;
         sWaitCdb: state_nxt = !cdb_ack ? sWaitCdb : accept ? (sel_sub ? sInverse : sAdd) : sIdle;
         default:  state_nxt = sIdle;
      endcase
   end

   // Subtract reuses the adder: invert b in sInverse, then add with carry-in in sMAdd.
   always_ff @(posedge clk)
      if (RST) begin
         state <= sIdle;
         a_q <= '0;
         b_q <= '0;
         tag_q <= '0;
         cdb_tag <= '0;
         cdb_data <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_q <= sel_a;
            b_q <= sel_b;
            tag_q <= sel_tag;
         end
         if (state == sInverse)
            b_q <= ~b_q;
         if (state == sAdd || state == sMAdd) begin
            cdb_data <= a_q + b_q + DATA_W'(state == sMAdd);
            cdb_tag <= tag_q;
         end
      end

endmodule

// File: tb/tb_add_unit_scheduler.sv
// tb_add_unit_scheduler: directed vectors with hand-computed results for the add unit scheduler.
module tb_add_unit_scheduler;
   import add_unit_scheduler_pkg::*;

   logic         clk = 0;
   logic         RST;
   logic [3:0]   rs_valid;
   logic [7:0]   rs_op;
   logic [127:0] rs_a, rs_b;
   logic [15:0]  rs_tag;
   logic [3:0]   rs_grant;
   logic         cdb_req, cdb_ack, busy;
   logic [3:0]   cdb_tag;
   logic [31:0]  cdb_data;
   int n_cmp = 0, n_bad = 0;

   add_unit_scheduler #(.N_RS(4), .DATA_W(32), .TAG_W(4)) dut (
      .clk(clk), .RST(RST), .rs_valid(rs_valid), .rs_op(rs_op), .rs_a(rs_a), .rs_b(rs_b),
      .rs_tag(rs_tag), .rs_grant(rs_grant), .cdb_req(cdb_req), .cdb_ack(cdb_ack),
      .cdb_tag(cdb_tag), .cdb_data(cdb_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_rs(input int i, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      rs_valid[i] = v;
      rs_op[2*i +: 2] = op;
      rs_a[32*i +: 32] = a;
      rs_b[32*i +: 32] = b;
      rs_tag[4*i +: 4] = tag;
   endtask

   // Advance one cycle; inputs change 1ns after the edge, checks run 2ns after that.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      RST = 1;
      step();
      step();
      RST = 0;
   endtask

   initial begin
      RST = 1; rs_valid = 0; rs_op = 0; rs_a = 0; rs_b = 0; rs_tag = 0; cdb_ack = 0;
      step();
      set_rs(0, 1, ALU_ADD, 1, 1, 1);
      settle();
      chk("grant_in_reset", 32'(rs_grant), 0);
      step();
      rs_valid = 0;
      RST = 0;
      settle();
      chk("rst_req", 32'(cdb_req), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_data", cdb_data, 0);
      chk("rst_tag", 32'(cdb_tag), 0);

      // reset mid-subtract
      set_rs(0, 1, ALU_SUB, 10, 3, 5);
      settle();
      chk("midsub_grant", 32'(rs_grant), 4'b0001);
      step();
      rs_valid = 0;
      RST = 1;
      set_rs(1, 1, ALU_ADD, 1, 2, 6);
      settle();
      chk("midsub_grant_rst", 32'(rs_grant), 0);
      step();
      RST = 0;
      rs_valid = 0;
      settle();
      chk("midsub_busy", 32'(busy), 0);
      for (int k = 0; k < 4; k++) begin
         chk("midsub_noreq", 32'(cdb_req), 0);
         step();
      end

      // single add, ack tied high
      cdb_ack = 1;
      set_rs(0, 1, ALU_ADD, 5, 7, 3);
      settle();
      chk("add_grant", 32'(rs_grant), 4'b0001);
      step();
      rs_valid = 0;
      settle();
      chk("add_t1_req", 32'(cdb_req), 0);
      chk("add_t1_busy", 32'(busy), 1);
      step();
      settle();
      chk("add_t2_req", 32'(cdb_req), 1);
      chk("add_data", cdb_data, 12);
      chk("add_tag", 32'(cdb_tag), 3);
      step();
      settle();
      chk("add_t3_busy", 32'(busy), 0);

      // subtract 3-5
      set_rs(1, 1, ALU_SUB, 3, 5, 4);
      settle();
      chk("sub_grant", 32'(rs_grant), 4'b0010);
      step();
      rs_valid = 0;
      settle();
      chk("sub_t1_req", 32'(cdb_req), 0);
      step();
      settle();
      chk("sub_t2_req", 32'(cdb_req), 0);
      step();
      settle();
      chk("sub_t3_req", 32'(cdb_req), 1);
      chk("sub_data", cdb_data, 32'hFFFF_FFFE);
      chk("sub_tag", 32'(cdb_tag), 4);
      step();

      // add with carry out dropped
      set_rs(2, 1, ALU_ADD, 32'hFFFF_FFFF, 1, 11);
      settle();
      chk("wrap_grant", 32'(rs_grant), 4'b0100);
      step();
      rs_valid = 0;
      step();
      settle();
      chk("wrap_req", 32'(cdb_req), 1);
      chk("wrap_data", cdb_data, 0);
      step();

      // round-robin fairness from a fresh pointer
      do_reset();
      cdb_ack = 1;
      for (int i = 0; i < 4; i++) set_rs(i, 1, ALU_ADD, 100 * i, i + 1, 4'(i + 8));
      for (int g = 0; g < 5; g++) begin
         settle();
         chk("rr_grant", 32'(rs_grant), 32'(1 << (g % 4)));
         if (g > 0) begin
            chk("rr_data", cdb_data, 100 * ((g - 1) % 4) + ((g - 1) % 4) + 1);
            chk("rr_tag", 32'(cdb_tag), ((g - 1) % 4) + 8);
         end
         step();
         settle();
         chk("rr_gap_grant", 32'(rs_grant), 0);
         step();
      end
      rs_valid = 0;
      step();
      step();

      // CDB backpressure; pointer is at 1 after the last grant to RS0
      cdb_ack = 0;
      set_rs(1, 1, ALU_ADD, 40, 2, 7);
      settle();
      chk("bp_grant", 32'(rs_grant), 4'b0010);
      step();
      rs_valid = 0;
      step();
      set_rs(3, 1, ALU_ADD, 1, 1, 9);
      for (int k = 0; k < 5; k++) begin
         settle();
         chk("bp_req", 32'(cdb_req), 1);
         chk("bp_data", cdb_data, 42);
         chk("bp_tag", 32'(cdb_tag), 7);
         chk("bp_nogrant", 32'(rs_grant), 0);
         step();
      end
      cdb_ack = 1;
      settle();
      chk("bp_ack_grant", 32'(rs_grant), 4'b1000);
      chk("bp_ack_data", cdb_data, 42);
      step();
      rs_valid = 0;
      settle();
      chk("bp_next_req", 32'(cdb_req), 0);
      step();
      settle();
      chk("bp_next_data", cdb_data, 2);
      chk("bp_next_tag", 32'(cdb_tag), 9);
      step();
      settle();
      chk("bp_idle", 32'(busy), 0);

      // ack outside window: idle, then during sInverse
      cdb_ack = 1;
      settle();
      chk("ack_idle_grant", 32'(rs_grant), 0);
      step();
      cdb_ack = 0;
      settle();
      chk("ack_idle_busy", 32'(busy), 0);
      set_rs(0, 1, ALU_SUB, 9, 4, 2);
      settle();
      chk("ai_grant", 32'(rs_grant), 4'b0001);
      step();
      rs_valid = 0;
      set_rs(1, 1, ALU_ADD, 1, 1, 1);
      cdb_ack = 1;
      settle();
      chk("ai_inv_grant", 32'(rs_grant), 0);
      step();
      cdb_ack = 0;
      rs_valid = 0;
      settle();
      chk("ai_madd_req", 32'(cdb_req), 0);
      chk("ai_madd_busy", 32'(busy), 1);
      step();
      settle();
      chk("ai_req", 32'(cdb_req), 1);
      chk("ai_data", cdb_data, 5);
      chk("ai_tag", 32'(cdb_tag), 2);
      cdb_ack = 1;
      step();
      settle();
      chk("ai_idle", 32'(busy), 0);

      // op 2'b10 executes as add
      set_rs(1, 1, 2'b10, 10, 3, 13);
      settle();
      chk("op10_grant", 32'(rs_grant), 4'b0010);
      step();
      rs_valid = 0;
      step();
      settle();
      chk("op10_req", 32'(cdb_req), 1);
      chk("op10_data", cdb_data, 13);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
